// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling driven by a
// per-state cycle counter, one-cycle valid / framing_err result pulses.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 25
) (
  input  logic       CLKIN,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_err,
  output logic       busy,
  output logic [2:0] fsm_state
);

  // Output protocol: valid and framing_err are single-cycle strobes with no
  // back-pressure; data is stable from a valid pulse until the next one.

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          sync1;
  logic          sync2;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          valid_pend;
  logic          ferr_pend;

  logic          shift_en;
  logic          stop_good;
  logic          stop_bad;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          next_state = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          next_state = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            stop_good  = 1'b1;
            next_state = IDLE;
          end else begin
            stop_bad   = 1'b1;
            next_state = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The counter restarts on every state change and at the end of each bit
  // period, so DATA re-arms for the next bit without leaving the state.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (state != DATA) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  end

  // Result strobes are held back one cycle so they appear one clock after
  // the stop-bit sample edge.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      data        <= 8'h00;
      valid_pend  <= 1'b0;
      ferr_pend   <= 1'b0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (stop_good) begin
        data <= shreg;
      end
      valid_pend  <= stop_good;
      ferr_pend   <= stop_bad;
      valid       <= valid_pend;
      framing_err <= ferr_pend;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized line activity,
// checked every cycle against an offset-based model of frame reception.
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int CPB25 = 25;

  logic       CLKIN = 1'b0;
  logic       RESET = 1'b1;
  logic       rx    = 1'b1;
  logic       rx25  = 1'b1;

  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       busy;
  logic [2:0] fsm_state;

  logic [7:0] data25;
  logic       valid25;
  logic       framing_err25;
  logic       busy25;
  logic [2:0] fsm_state25;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) u_dut (
    .CLKIN       (CLKIN),
    .RESET       (RESET),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .framing_err (framing_err),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  uart_rx_ctrl u_dut25 (
    .CLKIN       (CLKIN),
    .RESET       (RESET),
    .rx          (rx25),
    .data        (data25),
    .valid       (valid25),
    .framing_err (framing_err25),
    .busy        (busy25),
    .fsm_state   (fsm_state25)
  );

  // ---------------- clock / reset ----------------
  always #5 CLKIN = ~CLKIN;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) begin
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Frame reception expressed as offsets from the cycle the receiver leaves
  // idle; the line seen by the receiver is rx delayed by two edges.
  int         cyc = 0;
  logic       h1 = 1'b1;
  logic       h2 = 1'b1;
  int         m_start = -1;
  bit         m_wait = 1'b0;
  logic [7:0] m_bits = 8'h00;
  logic [7:0] m_data = 8'h00;
  int         exp_valid_cyc = -10;
  int         exp_fe_cyc = -10;

  initial begin
    forever begin
      @(posedge CLKIN or posedge RESET);
      if (RESET) begin
        h1 = 1'b1;
        h2 = 1'b1;
        m_start = -1;
        m_wait = 1'b0;
        m_bits = 8'h00;
        m_data = 8'h00;
        exp_valid_cyc = -10;
        exp_fe_cyc = -10;
      end else begin
        logic v;
        int   off;
        cyc++;
        v  = h2;
        h2 = h1;
        h1 = rx;
        if (m_wait) begin
          if (v) m_wait = 1'b0;
        end else if (m_start < 0) begin
          if (!v) m_start = cyc;
        end else begin
          off = cyc - m_start;
          if (off == HALF) begin
            if (v) m_start = -1;
          end else if (off > HALF && off < HALF + 9*CPB && ((off - HALF) % CPB) == 0) begin
            m_bits[(off - HALF)/CPB - 1] = v;
          end else if (off == HALF + 9*CPB) begin
            m_start = -1;
            if (v) begin
              m_data = m_bits;
              exp_valid_cyc = cyc + 1;
            end else begin
              m_wait = 1'b1;
              exp_fe_cyc = cyc + 1;
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [7:0] got_q[$];
  int v16_cnt = 0;
  int fe16_cnt = 0;
  int v25_cnt = 0;
  int last_v16_cyc = -1;
  int last_v25_cyc = -1;

  initial begin
    forever begin
      @(negedge CLKIN);
      if (valid) begin
        v16_cnt++;
        last_v16_cyc = cyc;
        got_q.push_back(data);
      end
      if (framing_err) fe16_cnt++;
      if (valid25) begin
        v25_cnt++;
        last_v25_cyc = cyc;
      end
      if (cmp_en) begin
        check("valid", {31'd0, valid}, {31'd0, (cyc == exp_valid_cyc) && !RESET});
        check("framing_err", {31'd0, framing_err}, {31'd0, (cyc == exp_fe_cyc) && !RESET});
        check("data", {24'd0, data}, {24'd0, m_data});
        check("busy", {31'd0, busy}, {31'd0, (m_start >= 0) || m_wait});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All driving starts 1 time unit after a rising edge.
  task automatic drive(input logic lvl, input int n, input bit sel25);
    if (sel25) rx25 = lvl;
    else rx = lvl;
    repeat (n) @(posedge CLKIN);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitlen, input bit sel25);
    drive(1'b0, bitlen, sel25);
    for (int i = 0; i < 8; i++) drive(b[i], bitlen, sel25);
    drive(stop, bitlen, sel25);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int n0;
    int fe0;
    logic [7:0] b;
    bit bad;
    int len;

    RESET = 1'b1;
    repeat (3) @(posedge CLKIN);
    #1;
    RESET = 1'b0;
    cmp_en = 1'b1;
    @(negedge CLKIN);
    check("rst_data", {24'd0, data}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);
    check("rst_ferr", {31'd0, framing_err}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    @(posedge CLKIN);
    #1;
    drive(1'b1, 5, 1'b0);

    // Good frame: START entry 3 edges after the drive edge, valid 153 later.
    t0 = cyc;
    n0 = v16_cnt;
    send_frame(8'hA5, 1'b1, CPB, 1'b0);
    drive(1'b1, 10, 1'b0);
    check("good_latency", last_v16_cyc - t0, 156);
    check("good_count", v16_cnt - n0, 1);
    check("good_data", {24'd0, data}, 32'hA5);
    check("good_busy_after", {31'd0, busy}, 32'h0);

    // Glitch shorter than half a bit.
    n0 = v16_cnt;
    fe0 = fe16_cnt;
    drive(1'b0, 3, 1'b0);
    drive(1'b1, 30, 1'b0);
    check("glitch_valid", v16_cnt - n0, 0);
    check("glitch_ferr", fe16_cnt - fe0, 0);
    check("glitch_data", {24'd0, data}, 32'hA5);
    check("glitch_busy", {31'd0, busy}, 32'h0);

    // Framing error followed by a held-low break.
    n0 = v16_cnt;
    fe0 = fe16_cnt;
    send_frame(8'h3C, 1'b0, CPB, 1'b0);
    drive(1'b0, 100, 1'b0);
    check("ferr_count", fe16_cnt - fe0, 1);
    check("ferr_valid", v16_cnt - n0, 0);
    check("ferr_data", {24'd0, data}, 32'hA5);
    check("ferr_busy_hold", {31'd0, busy}, 32'h1);
    drive(1'b1, 6, 1'b0);
    check("ferr_busy_release", {31'd0, busy}, 32'h0);

    // Back-to-back frames with no idle time on the line.
    n0 = got_q.size();
    fe0 = fe16_cnt;
    send_frame(8'h00, 1'b1, CPB, 1'b0);
    send_frame(8'hFF, 1'b1, CPB, 1'b0);
    drive(1'b1, 10, 1'b0);
    check("b2b_count", got_q.size() - n0, 2);
    check("b2b_first", (got_q.size() > n0) ? {24'd0, got_q[n0]} : 32'hDEAD, 32'h00);
    check("b2b_second", (got_q.size() > n0 + 1) ? {24'd0, got_q[n0+1]} : 32'hDEAD, 32'hFF);
    check("b2b_ferr", fe16_cnt - fe0, 0);

    // Reset in the middle of the data bits.
    n0 = v16_cnt;
    fe0 = fe16_cnt;
    drive(1'b0, CPB, 1'b0);
    for (int i = 0; i < 4; i++) drive(i[0], CPB, 1'b0);
    #1;
    RESET = 1'b1;
    #1;
    check("rst_mid_data", {24'd0, data}, 32'h0);
    check("rst_mid_valid", {31'd0, valid}, 32'h0);
    check("rst_mid_ferr", {31'd0, framing_err}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'h0);
    rx = 1'b1;
    repeat (2) @(posedge CLKIN);
    #1;
    RESET = 1'b0;
    drive(1'b1, 200, 1'b0);
    check("rst_mid_nopulse", (v16_cnt - n0) + (fe16_cnt - fe0), 0);
    send_frame(8'h81, 1'b1, CPB, 1'b0);
    drive(1'b1, 10, 1'b0);
    check("rst_after_count", v16_cnt - n0, 1);
    check("rst_after_data", {24'd0, data}, 32'h81);

    // Default bit period: stop sample 237 after START entry, valid one later.
    t0 = cyc;
    n0 = v25_cnt;
    send_frame(8'h5A, 1'b1, CPB25, 1'b1);
    drive(1'b1, 10, 1'b1);
    check("dflt_latency", last_v25_cyc - t0, 241);
    check("dflt_count", v25_cnt - n0, 1);
    check("dflt_data", {24'd0, data25}, 32'h5A);

    // Randomized frames, errors, glitches and bit-period jitter.
    for (int f = 0; f < 40; f++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0);
      len = $urandom_range(CPB - 1, CPB + 1);
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, $urandom_range(1, 7), 1'b0);
        drive(1'b1, $urandom_range(1, 10), 1'b0);
      end
      send_frame(b, !bad, len, 1'b0);
      if (bad) drive(1'b0, $urandom_range(1, 40), 1'b0);
      drive(1'b1, $urandom_range(1, 30), 1'b0);
    end

    // Unstructured line noise.
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 40), 1'b0);
    end
    drive(1'b1, 250, 1'b0);
    check("end_busy", {31'd0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 25, SHALL give the number of CLKIN cycles per serial bit; legal range 4..255.
REQ-002 CLKIN  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 rx  input  1  SHALL carry the asynchronous serial line: idle high, 8N1 framing, LSB first.
REQ-005 data  output  8  SHALL hold the last correctly framed received byte.
REQ-006 valid  output  1  SHALL be a one-cycle pulse marking a new byte on data.
REQ-007 framing_err  output  1  SHALL be a one-cycle pulse marking a frame whose stop bit sampled low.
REQ-008 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; rx_s is the synchronizer output. All FSM decisions SHALL use rx_s only.
REQ-010 Derived constant H SHALL equal CLKS_PER_BIT/2, using integer division.
REQ-011 Bit counter cnt SHALL be wide enough for CLKS_PER_BIT-1.
  - cnt SHALL clear on every state transition.
  - cnt SHALL increment each cycle otherwise.
  - cnt SHALL never wrap past CLKS_PER_BIT-1.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 IDLE: rx_s==0 SHALL move the FSM to START on the next edge; otherwise it stays in IDLE.
REQ-014 START: when cnt==H-1, rx_s SHALL be resampled.
  - rx_s==0: go to DATA.
  - rx_s==1: treat as a glitch and go to IDLE; no valid and no framing_err pulse.
REQ-015 DATA: when cnt==CLKS_PER_BIT-1, rx_s SHALL shift into an 8-bit shift register, LSB first, and a 3-bit bit index SHALL increment.
  - After the 8th sample the FSM SHALL go to STOP.
  - The bit index SHALL be 0 on DATA entry.
REQ-016 STOP: when cnt==CLKS_PER_BIT-1, rx_s SHALL be sampled.
  - rx_s==1: data SHALL load the shift register, valid SHALL pulse in the next cycle, and the FSM SHALL go to IDLE.
  - rx_s==0: data SHALL stay unchanged, framing_err SHALL pulse in the next cycle, and the FSM SHALL go to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL stay until rx_s==1, then go to IDLE; a held-low line (break) SHALL NOT produce further frames or pulses.
REQ-018 Sample points SHALL fall at these offsets after START entry:
  - start-bit check: H cycles;
  - data bit k (k=0..7): H+(k+1)*CLKS_PER_BIT cycles;
  - stop bit: H+9*CLKS_PER_BIT cycles.
REQ-019 valid or framing_err SHALL assert exactly 1 cycle after the stop sample and deassert the following cycle.
  - valid and framing_err SHALL never be high together.
REQ-020 Back-to-back frames: if rx_s==0 in the first IDLE cycle after a good stop bit, the next frame SHALL be accepted with no lost cycle beyond the IDLE cycle.
REQ-021 data SHALL hold its value between valid pulses and SHALL be unaffected by glitch rejection or framing errors.
REQ-022 rx transitions during DATA or STOP SHALL be ignored except at the sample points.

Reset
REQ-023 While RESET is high, the block SHALL immediately (asynchronously) force:
  - FSM to IDLE;
  - cnt, bit index and shift register to 0;
  - data to 0x00;
  - valid, framing_err and busy to 0;
  - both synchronizer flops to 1.
REQ-024 RESET asserted mid-frame SHALL abandon the frame with no valid or framing_err pulse; after release the block SHALL wait for a fresh start bit.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Good frame: CLKS_PER_BIT=16, send 0xA5 with an 8N1 high stop bit -> data=0xA5, valid high for exactly 1 cycle, 153 cycles after START entry; busy low afterward.
  - Glitch: rx low for 3 cycles, then high (CLKS_PER_BIT=16) -> FSM returns to IDLE; no valid, no framing_err; data unchanged.
  - Framing error: send 0x3C with stop bit low, then hold rx low for 100 cycles -> framing_err pulses once, data keeps its prior value, FSM stays in WAIT_HIGH until rx high, then IDLE.
  - Back-to-back: frames 0x00 then 0xFF with no idle gap -> two valid pulses, data=0x00 then 0xFF, no framing_err.
  - Reset mid-frame: RESET pulse during DATA after 4 bits -> outputs 0 asynchronously, no pulse; a following 0x81 frame is received correctly.
  - Default parameter: CLKS_PER_BIT=25, send 0x5A -> valid 1 cycle after the stop sample at H+9*25=237 cycles after START entry; data=0x5A.
